// File: rtl/write_back_stage.sv
// write_back_stage: registered MEM/WB stage with load formatting, result select,
// x0 suppression, misaligned-load flag and retired-instruction counter.
module write_back_stage #(
  parameter int RA_W        = 5,
  parameter int CNT_W       = 64,
  parameter bit SUPPRESS_X0 = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_w,
  input  logic             flush_w,
  input  logic             valid_m,
  input  logic             reg_write_m,
  input  logic [1:0]       result_src_m,
  input  logic [2:0]       funct3_m,
  input  logic [31:0]      read_data_m,
  input  logic [31:0]      alu_out_m,
  input  logic [31:0]      pc_plus4_m,
  input  logic [31:0]      imm_m,
  input  logic [RA_W-1:0]  rd_m,
  output logic [31:0]      result_w,
  output logic             reg_write_w,
  output logic [RA_W-1:0]  rd_w,
  output logic             valid_w,
  output logic             misaligned_w,
  output logic [CNT_W-1:0] instret
);
  logic             valid_q, reg_write_q, mis_q, mis_m;
  logic [1:0]       src_q, off_m;
  logic [2:0]       f3_q;
  logic [31:0]      rdata_q, alu_q, pc_q, imm_q, shifted, load_data;
  logic [15:0]      half;
  logic [7:0]       byte_v;
  logic [RA_W-1:0]  rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             is_x0;
  assign off_m = alu_out_m[1:0];
  // halfword loads need an even offset, word loads a zero offset
  assign mis_m = valid_m & (result_src_m == 2'b01) &
                 (((funct3_m[1:0] == 2'b01) & off_m[0]) | ((funct3_m == 3'b010) & (|off_m)));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mis_q       <= 1'b0;
      src_q       <= '0;
      f3_q        <= '0;
      rdata_q     <= '0;
      alu_q       <= '0;
      pc_q        <= '0;
      imm_q       <= '0;
      rd_q        <= '0;
    end else if (flush_w) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mis_q       <= 1'b0;
    end else if (!stall_w) begin
      valid_q     <= valid_m;
      reg_write_q <= reg_write_m;
      mis_q       <= mis_m;
      src_q       <= result_src_m;
      f3_q        <= funct3_m;
      rdata_q     <= read_data_m;
      alu_q       <= alu_out_m;
      pc_q        <= pc_plus4_m;
      imm_q       <= imm_m;
      rd_q        <= rd_m;
    end
  end
  // an instruction retires on the edge it leaves WB, so a stalled one counts once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else if (valid_q && !stall_w) cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end
  always_comb begin
    shifted   = rdata_q >> {alu_q[1:0], 3'b000};
    byte_v    = shifted[7:0];
    half      = alu_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    load_data = (f3_q == 3'b000) ? {{24{byte_v[7]}}, byte_v} :
                (f3_q == 3'b100) ? {24'b0, byte_v} :
                (f3_q == 3'b001) ? {{16{half[15]}}, half} :
                (f3_q == 3'b101) ? {16'b0, half} : rdata_q;
    result_w  = (src_q == 2'b00) ? alu_q :
                (src_q == 2'b01) ? load_data :
                (src_q == 2'b10) ? pc_q : imm_q;
  end
  assign is_x0        = SUPPRESS_X0 && (rd_q == '0);
  assign valid_w      = valid_q;
  assign misaligned_w = valid_q & mis_q;
  assign reg_write_w  = valid_q & reg_write_q & ~misaligned_w & ~is_x0;
  assign rd_w         = rd_q;
  assign instret      = cnt_q;
endmodule

// File: tb/tb_write_back_stage.sv
// tb_write_back_stage: directed plan cases plus randomized traffic against a behavioural model.
module tb_write_back_stage;
  logic        clk = 1'b0, rst_n = 1'b0, stall_w = 1'b0, flush_w = 1'b0;
  logic        valid_m = 1'b0, reg_write_m = 1'b0;
  logic [1:0]  result_src_m = '0;
  logic [2:0]  funct3_m = '0;
  logic [31:0] read_data_m = '0, alu_out_m = '0, pc_plus4_m = '0, imm_m = '0;
  logic [4:0]  rd_m = '0;
  logic [31:0] result_w;
  logic        reg_write_w, valid_w, misaligned_w;
  logic [4:0]  rd_w;
  logic [3:0]  instret;
  int n_checks = 0, n_pass = 0;
  // model of the instruction sitting in WB
  bit          m_valid, m_rw;
  int unsigned m_src, m_f3, m_rd, m_cnt;
  logic [31:0] m_rdata, m_alu, m_pc, m_imm;
  logic [31:0] saved_res;
  int unsigned saved_cnt;
  always #5 clk = ~clk;
  write_back_stage #(.RA_W(5), .CNT_W(4), .SUPPRESS_X0(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .stall_w(stall_w), .flush_w(flush_w), .valid_m(valid_m),
    .reg_write_m(reg_write_m), .result_src_m(result_src_m), .funct3_m(funct3_m),
    .read_data_m(read_data_m), .alu_out_m(alu_out_m), .pc_plus4_m(pc_plus4_m), .imm_m(imm_m),
    .rd_m(rd_m), .result_w(result_w), .reg_write_w(reg_write_w), .rd_w(rd_w), .valid_w(valid_w),
    .misaligned_w(misaligned_w), .instret(instret));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  function automatic logic [31:0] fmt(input int unsigned f3, input logic [31:0] rdata, input int unsigned off);
    int unsigned b, h;
    b = (rdata >> (8 * off)) & 32'hFF;
    h = (rdata >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      0: return (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
      4: return 32'(b);
      1: return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
      5: return 32'(h);
      default: return rdata;
    endcase
  endfunction
  function automatic bit exp_mis();
    int unsigned off;
    off = m_alu % 4;
    return m_valid && m_src == 1 &&
           (((m_f3 == 1 || m_f3 == 5) && off % 2 == 1) || (m_f3 == 2 && off != 0));
  endfunction
  function automatic logic [31:0] exp_res();
    case (m_src)
      0: return m_alu;
      1: return fmt(m_f3, m_rdata, m_alu % 4);
      2: return m_pc;
      default: return m_imm;
    endcase
  endfunction
  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_src = 0; m_f3 = 0; m_rd = 0; m_cnt = 0;
    m_rdata = 0; m_alu = 0; m_pc = 0; m_imm = 0;
  endtask
  task automatic check_all();
    chk("valid_w", valid_w, m_valid);
    chk("misaligned_w", misaligned_w, exp_mis());
    chk("reg_write_w", reg_write_w, m_valid && m_rw && !exp_mis() && m_rd != 0);
    chk("instret", instret, m_cnt);
    if (m_valid) begin
      chk("result_w", result_w, exp_res());
      chk("rd_w", rd_w, m_rd);
    end
  endtask
  task automatic step();
    @(posedge clk);
    if (m_valid && !stall_w) m_cnt = (m_cnt + 1) % 16;
    if (flush_w) begin
      m_valid = 0; m_rw = 0;
    end else if (!stall_w) begin
      m_valid = valid_m; m_rw = reg_write_m; m_src = result_src_m; m_f3 = funct3_m;
      m_rdata = read_data_m; m_alu = alu_out_m; m_pc = pc_plus4_m; m_imm = imm_m; m_rd = rd_m;
    end
    #1;
    check_all();
  endtask
  task automatic drive(input logic v, input logic rw, input logic [1:0] src, input logic [2:0] f3,
                       input logic [31:0] rdat, input logic [31:0] alu, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [4:0] rd);
    valid_m = v; reg_write_m = rw; result_src_m = src; funct3_m = f3;
    read_data_m = rdat; alu_out_m = alu; pc_plus4_m = pc; imm_m = imm; rd_m = rd;
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, valid_w, 1'b0);
    chk({tag, "_result"}, result_w, 32'h0);
    chk({tag, "_we"}, reg_write_w, 1'b0);
    chk({tag, "_rd"}, rd_w, 5'd0);
    chk({tag, "_mis"}, misaligned_w, 1'b0);
    chk({tag, "_instret"}, instret, 4'd0);
  endtask
  initial begin
    model_reset();
    #12;
    check_zero("reset");
    rst_n = 1'b1;
    // counter wrap: 17 retirements on a 4-bit counter leave 1
    for (int i = 0; i < 17; i++) begin
      drive(1, 1, 2'b00, 3'b000, 0, 32'(i), 0, 0, 5'd3);
      step();
    end
    drive(0, 0, 2'b00, 3'b000, 0, 0, 0, 0, 5'd0);
    step();
    chk("wrap_instret", instret, 4'd1);
    drive(1, 1, 2'b01, 3'b000, 32'h80FF7F01, 32'h3, 0, 0, 5'd7);
    step();
    chk("lb_off3", result_w, 32'hFFFFFF80);
    drive(1, 1, 2'b01, 3'b100, 32'h80FF7F01, 32'h3, 0, 0, 5'd7);
    step();
    chk("lbu_off3", result_w, 32'h00000080);
    drive(1, 1, 2'b01, 3'b001, 32'h80FF7F01, 32'h2, 0, 0, 5'd7);
    step();
    chk("lh_off2", result_w, 32'hFFFF80FF);
    drive(1, 1, 2'b01, 3'b101, 32'h80FF7F01, 32'h2, 0, 0, 5'd7);
    step();
    chk("lhu_off2", result_w, 32'h000080FF);
    drive(1, 1, 2'b01, 3'b010, 32'h12345678, 32'h2, 0, 0, 5'd5);
    step();
    chk("lw_mis_flag", misaligned_w, 1'b1);
    chk("lw_mis_we", reg_write_w, 1'b0);
    saved_cnt = m_cnt;
    drive(1, 1, 2'b10, 3'b000, 0, 0, 32'h104, 0, 5'd1);
    step();
    chk("lw_mis_retired", instret, 4'((saved_cnt + 1) % 16));
    chk("link_result", result_w, 32'h104);
    chk("link_we", reg_write_w, 1'b1);
    drive(1, 1, 2'b10, 3'b000, 0, 0, 32'h104, 0, 5'd0);
    step();
    chk("link_x0_we", reg_write_w, 1'b0);
    // stall for three cycles while MEM inputs keep changing
    saved_res = result_w;
    saved_cnt = m_cnt + 1;
    step();
    stall_w = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 2'b11, 3'b000, 0, 0, 0, 32'hABC0 + 32'(i), 5'd9);
      step();
      chk("stall_hold_result", result_w, saved_res);
      chk("stall_hold_instret", instret, 4'(saved_cnt % 16));
    end
    stall_w = 1'b0;
    step();
    chk("stall_release_instret", instret, 4'((saved_cnt + 1) % 16));
    chk("stall_release_result", result_w, 32'hABC2);
    stall_w = 1'b1; flush_w = 1'b1;
    step();
    chk("flush_stall_valid", valid_w, 1'b0);
    stall_w = 1'b0; flush_w = 1'b0;
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 1'($urandom), 2'($urandom), 3'($urandom), $urandom, $urandom,
            $urandom, $urandom, 5'($urandom));
      stall_w = ($urandom_range(0, 4) == 0);
      flush_w = ($urandom_range(0, 9) == 0);
      step();
    end
    stall_w = 1'b0; flush_w = 1'b0;
    drive(1, 1, 2'b00, 3'b000, 0, 32'h55, 0, 0, 5'd4);
    step();
    // asynchronous reset between clock edges
    #2 rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    model_reset();
    #2 rst_n = 1'b1;
    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
